// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result bundle between an ALU requester and alu_seq
// Purpose: groups the ALU request and result signals so they travel as one port.
// Signals:
//   start_i            requester -> ALU  request strobe
//   ctrl_i[3:0]        requester -> ALU  operation code
//   src1_i/src2_i      requester -> ALU  operands A/B, WIDTH bits
//   busy_o             ALU -> requester  multi-cycle operation in progress
//   done_o             ALU -> requester  one-cycle completion pulse
//   result_o           ALU -> requester  registered result, WIDTH bits
//   zero_o             ALU -> requester  registered (result_o == 0)
// Modports: master (requester side), slave (ALU side).
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  busy_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output busy_o, done_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle logic/arith ops and optional shift-add MUL
// Purpose: accepts a request when idle, returns a registered result with a one-cycle done pulse.
//   Single-cycle ops: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NAND 1101.
//   Any other code completes in one cycle with result 0.
// Configuration: define ALU_SEQ_MUL_EN to add code 1000, an unsigned WIDTH-step
//   shift-add multiply (low WIDTH bits kept). Undefined: no MUL datapath, busy_o tied 0.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   bus     alu_seq_if.slave: start_i, ctrl_i, src1_i, src2_i in; busy_o, done_o, result_o, zero_o out
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  logic [WIDTH-1:0] w_alu;
  logic             w_alu_zero;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;

  // Single-cycle datapath; unrecognised codes (and MUL here) give 0.
  always_comb begin
    w_alu = '0;
    case (bus.ctrl_i)
      OP_AND:  w_alu = bus.src1_i & bus.src2_i;
      OP_OR:   w_alu = bus.src1_i | bus.src2_i;
      OP_ADD:  w_alu = bus.src1_i + bus.src2_i;
      OP_SUB:  w_alu = bus.src1_i - bus.src2_i;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      OP_NOR:  w_alu = ~(bus.src1_i | bus.src2_i);
      OP_NAND: w_alu = ~(bus.src1_i & bus.src2_i);
      default: w_alu = '0;
    endcase
  end

  assign w_alu_zero = (w_alu == '0);

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_next;

  // One shift-add step: add the (pre-shifted) multiplicand when the current multiplier LSB is set.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            if (bus.ctrl_i == OP_MUL) begin
              r_state  <= S_MUL;
              r_busy   <= 1'b1;
              r_mcand  <= bus.src1_i;
              r_mplier <= bus.src2_i;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_result <= w_alu;
              r_zero   <= w_alu_zero;
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_done   <= 1'b0;
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // The WIDTH-th step publishes the product directly from the adder.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o = r_busy;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= bus.start_i;
      if (bus.start_i) begin
        r_result <= w_alu;
        r_zero   <= w_alu_zero;
      end
    end
  end

  assign bus.busy_o = 1'b0;
`endif

  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
  assign bus.zero_o   = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a result scoreboard
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] prev_res = '0;

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [W-1:0] res);
    exp_t e;
    e.res  = res;
    e.zero = (res == '0);
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic req(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    bus.start_i = 1'b1;
    bus.ctrl_i  = c;
    bus.src1_i  = a;
    bus.src2_i  = b;
  endtask

  task automatic idle();
    bus.start_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(string tag, int max_cycles);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (bus.done_o) begin
        got = 1'b1;
        break;
      end
    end
    check1(tag, got, 1'b1);
  endtask

  function automatic logic [W-1:0] model(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1101: return ~(a & b);
      default: return '0;
    endcase
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding request,
  // and result_o must not move on cycles without done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.done_o) begin
        check1("done_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check({e.tag, "_result"}, bus.result_o, e.res);
          check1({e.tag, "_zero"}, bus.zero_o, e.zero);
        end
      end else begin
        check("result_hold", bus.result_o, prev_res);
      end
    end
    prev_res = bus.result_o;
  end

  logic [3:0]   t_op [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b0111, 4'b1100, 4'b1101};
  logic [W-1:0] t_a  [9] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001,
                             32'h80000000, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
  logic [W-1:0] t_b  [9] = '{32'hFF00FF00, 32'h0F0F0000, 32'h00000001, 32'h00000001, 32'hFFFFFFFF,
                             32'h7FFFFFFF, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
  logic [W-1:0] t_r  [9] = '{32'hF000F000, 32'hFFFFF0F0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
                             32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
  logic [3:0]   ops  [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b0011};

  initial begin
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         saw_done;

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.ctrl_i  = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (2) tick();
    check1("rst_busy", bus.busy_o, 1'b0);
    check1("rst_done", bus.done_o, 1'b0);
    check("rst_result", bus.result_o, '0);
    check1("rst_zero", bus.zero_o, 1'b1);

    // First accept on the first rising edge after release.
    rst = 1'b0;
    req(4'b0010, 32'h00000005, 32'h00000003); push("add_5_3", 32'h00000008);
    tick();
    check1("add_done", bus.done_o, 1'b1);
    check1("add_busy", bus.busy_o, 1'b0);

    // Back-to-back, including accept during a done cycle.
    req(4'b0110, 32'h00000007, 32'h00000007); push("sub_7_7", 32'h00000000);
    tick();
    check1("sub_done", bus.done_o, 1'b1);
    req(4'b0111, 32'hFFFFFFFF, 32'h00000001); push("slt_m1_1", 32'h00000001);
    tick();
    check1("slt_done", bus.done_o, 1'b1);
    req(4'b0011, 32'hDEADBEEF, 32'h12345678); push("bad_op", 32'h00000000);
    tick();
    check1("bad_op_done", bus.done_o, 1'b1);

    for (int i = 0; i < 9; i++) begin
      req(t_op[i], t_a[i], t_b[i]); push($sformatf("tbl%0d", i), t_r[i]);
      tick();
      check1($sformatf("tbl%0d_done", i), bus.done_o, 1'b1);
    end
    idle();
    tick();
    check1("done_single_pulse", bus.done_o, 1'b0);
    tick();
    check1("done_stays_low", bus.done_o, 1'b0);

    for (int i = 0; i < 8; i++) begin
      c = ops[$urandom_range(0, 7)];
      a = $urandom();
      b = $urandom();
      req(c, a, b); push($sformatf("rnd%0d_op%b", i, c), model(c, a, b));
      tick();
      check1($sformatf("rnd%0d_done", i), bus.done_o, 1'b1);
    end
    idle();
    tick();

`ifdef ALU_SEQ_MUL_EN
    req(4'b1000, 32'h00010001, 32'h00000003); push("mul_a", 32'h00030003);
    tick();
    check1("mul_a_busy_first", bus.busy_o, 1'b1);
    check1("mul_a_no_done", bus.done_o, 1'b0);
    idle();
    for (int k = 1; k < 32; k++) begin
      if (k == 5 || k == 10) req(4'b0010, 32'h00000009, 32'h00000009);
      else idle();
      tick();
      check1($sformatf("mul_a_busy_%0d", k), bus.busy_o, 1'b1);
    end
    idle();
    tick();
    check1("mul_a_done_cycle33", bus.done_o, 1'b1);
    check1("mul_a_busy_clear", bus.busy_o, 1'b0);
    tick();

    req(4'b1000, 32'hFFFFFFFF, 32'h00000002); push("mul_trunc", 32'hFFFFFFFE);
    tick();
    idle();
    wait_done("mul_trunc_done", 40);
    tick();

    // Reset aborts an in-flight multiply.
    req(4'b1000, 32'h12345678, 32'h9ABCDEF1);
    tick();
    idle();
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check1("abort_busy", bus.busy_o, 1'b0);
    check1("abort_done", bus.done_o, 1'b0);
    check("abort_result", bus.result_o, '0);
    check1("abort_zero", bus.zero_o, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done_o) saw_done = 1'b1;
    end
    check1("abort_no_done", saw_done, 1'b0);
`else
    req(4'b1000, 32'hFFFFFFFF, 32'h00000002); push("mul_off", 32'h00000000);
    tick();
    check1("mul_off_done", bus.done_o, 1'b1);
    check1("mul_off_busy", bus.busy_o, 1'b0);
    idle();
    tick();

    req(4'b0010, 32'h00000003, 32'h00000004); push("add_3_4", 32'h00000007);
    tick();
    idle();
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_result", bus.result_o, '0);
    check1("rst_mid_zero", bus.zero_o, 1'b1);
    tick();
    rst = 1'b0;
`endif

    req(4'b0010, 32'h00000001, 32'h00000001); push("add_1_1", 32'h00000002);
    tick();
    check1("post_rst_add_done", bus.done_o, 1'b1);
    idle();
    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
